// File: rtl/doy_calc_sched.sv
// Round-robin front end that shares one day-of-year calculator between two requesters.
// Define DOY_SCHED_ERR_CHECK_EN to build the date validity check; otherwise respErr is tied 0.

module dayOfYrCalc #(
  parameter logic cal_select = 1'b0
) (
  input  logic [5:0]  dayOfMonth,
  input  logic [3:0]  month,
  input  logic [10:0] year,
  output logic [8:0]  dayOfYear
);
  logic        leap;
  logic [8:0]  cum;
  logic [10:0] r4, r100, r400;

  assign r4   = year % 11'd4;
  assign r100 = year % 11'd100;
  assign r400 = year % 11'd400;
  assign leap = cal_select ? (r4 == 11'd0)
                           : ((r4 == 11'd0) && ((r100 != 11'd0) || (r400 == 11'd0)));

  // Days before the month in a common year; months outside 1..12 contribute nothing.
  always_comb begin
    cum = 9'd0;
    case (month)
      4'd2:    cum = 9'd31;
      4'd3:    cum = 9'd59;
      4'd4:    cum = 9'd90;
      4'd5:    cum = 9'd120;
      4'd6:    cum = 9'd151;
      4'd7:    cum = 9'd181;
      4'd8:    cum = 9'd212;
      4'd9:    cum = 9'd243;
      4'd10:   cum = 9'd273;
      4'd11:   cum = 9'd304;
      4'd12:   cum = 9'd334;
      default: cum = 9'd0;
    endcase
  end

  assign dayOfYear = cum + {3'b000, dayOfMonth} + {8'b0, leap && (month > 4'd2)};
endmodule

module doy_calc_sched #(
  parameter logic cal_select = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0Valid,
  output logic        req0Ready,
  input  logic [5:0]  req0DayOfMonth,
  input  logic [3:0]  req0Month,
  input  logic [10:0] req0Year,
  input  logic        req1Valid,
  output logic        req1Ready,
  input  logic [5:0]  req1DayOfMonth,
  input  logic [3:0]  req1Month,
  input  logic [10:0] req1Year,
  output logic        respValid,
  input  logic        respReady,
  output logic        respId,
  output logic        respErr,
  output logic [8:0]  dayOfYear
);
  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;
  typedef struct packed {
    logic [5:0]  day;
    logic [3:0]  month;
    logic [10:0] year;
  } date_t;

  state_t     state_q, state_d;
  date_t      opnd_q;
  logic       opId_q, lastGrant_q, gntId, hs;
  logic [8:0] calcDoy, resDoy;
  logic       resErr;

  // With both requesting, the one not served last wins.
  assign gntId = (req0Valid && req1Valid) ? ~lastGrant_q : req1Valid;

  always_comb begin
    state_d   = state_q;
    hs        = 1'b0;
    req0Ready = 1'b0;
    req1Ready = 1'b0;
    case (state_q)
      IDLE: if (req0Valid || req1Valid) begin
        hs        = 1'b1;
        req0Ready = ~gntId;
        req1Ready = gntId;
        state_d   = CALC;
      end
      CALC:    state_d = RESP;
      RESP:    if (respReady) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      opnd_q      <= '0;
      opId_q      <= 1'b0;
      lastGrant_q <= 1'b1;
      respValid   <= 1'b0;
      respId      <= 1'b0;
      respErr     <= 1'b0;
      dayOfYear   <= 9'd0;
    end else begin
      if (hs) begin
        opnd_q      <= gntId ? date_t'({req1DayOfMonth, req1Month, req1Year})
                             : date_t'({req0DayOfMonth, req0Month, req0Year});
        opId_q      <= gntId;
        lastGrant_q <= gntId;
      end
      if (state_q == CALC) begin
        respValid <= 1'b1;
        respId    <= opId_q;
        respErr   <= resErr;
        dayOfYear <= resDoy;
      end else if (state_q == RESP && respReady) begin
        respValid <= 1'b0;
      end
    end
  end

  dayOfYrCalc #(.cal_select(cal_select)) u_calc (
    .dayOfMonth (opnd_q.day),
    .month      (opnd_q.month),
    .year       (opnd_q.year),
    .dayOfYear  (calcDoy)
  );

`ifdef DOY_SCHED_ERR_CHECK_EN
  logic        chkLeap;
  logic [5:0]  dim;
  logic [10:0] c4, c100, c400;

  assign c4      = opnd_q.year % 11'd4;
  assign c100    = opnd_q.year % 11'd100;
  assign c400    = opnd_q.year % 11'd400;
  assign chkLeap = cal_select ? (c4 == 11'd0)
                              : ((c4 == 11'd0) && ((c100 != 11'd0) || (c400 == 11'd0)));

  always_comb begin
    dim = 6'd31;
    case (opnd_q.month)
      4'd2:                   dim = chkLeap ? 6'd29 : 6'd28;
      4'd4, 4'd6, 4'd9, 4'd11: dim = 6'd30;
      default:                dim = 6'd31;
    endcase
  end

  assign resErr = (opnd_q.month == 4'd0) || (opnd_q.month > 4'd12) ||
                  (opnd_q.day == 6'd0) || (opnd_q.day > dim);
  assign resDoy = resErr ? 9'd0 : calcDoy;
`else
  assign resErr = 1'b0;
  assign resDoy = calcDoy;
`endif
endmodule

// File: tb/tb_doy_calc_sched.sv
// Directed bench for doy_calc_sched: Gregorian and Julian instances share stimulus,
// results are checked against a scoreboard filled when each request is driven.

module tb_doy_calc_sched;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0Valid = 1'b0, req1Valid = 1'b0, respReady = 1'b0;
  logic [5:0]  req0DayOfMonth = '0, req1DayOfMonth = '0;
  logic [3:0]  req0Month = '0, req1Month = '0;
  logic [10:0] req0Year = '0, req1Year = '0;
  logic        rdy0[2], rdy1[2], rv[2], rid[2], rerr[2];
  logic [8:0]  doy[2];

  always #5 clk = ~clk;

  doy_calc_sched #(.cal_select(1'b0)) dut_g (
    .clk(clk), .rst_n(rst_n),
    .req0Valid(req0Valid), .req0Ready(rdy0[0]), .req0DayOfMonth(req0DayOfMonth),
    .req0Month(req0Month), .req0Year(req0Year),
    .req1Valid(req1Valid), .req1Ready(rdy1[0]), .req1DayOfMonth(req1DayOfMonth),
    .req1Month(req1Month), .req1Year(req1Year),
    .respValid(rv[0]), .respReady(respReady), .respId(rid[0]), .respErr(rerr[0]),
    .dayOfYear(doy[0]));

  doy_calc_sched #(.cal_select(1'b1)) dut_j (
    .clk(clk), .rst_n(rst_n),
    .req0Valid(req0Valid), .req0Ready(rdy0[1]), .req0DayOfMonth(req0DayOfMonth),
    .req0Month(req0Month), .req0Year(req0Year),
    .req1Valid(req1Valid), .req1Ready(rdy1[1]), .req1DayOfMonth(req1DayOfMonth),
    .req1Month(req1Month), .req1Year(req1Year),
    .respValid(rv[1]), .respReady(respReady), .respId(rid[1]), .respErr(rerr[1]),
    .dayOfYear(doy[1]));

  typedef struct packed {
    logic       id;
    logic [8:0] dg;
    logic       eg;
    logic [8:0] dj;
    logic       ej;
  } exp_t;

  exp_t       q[$];
  int         checks = 0, errors = 0;
  int         cyc = 0, hs_cyc = -100;
  logic       hs0 = 1'b0, hs1 = 1'b0;
  logic       prv_rv[2], prv_id[2], prv_err[2], prv_rr;
  logic [8:0] prv_doy[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int mlen(input int m, input int lp);
    case (m)
      2:             return 28 + lp;
      4, 6, 9, 11:   return 30;
      default:       return 31;
    endcase
  endfunction

  function automatic void model(input int d, input int m, input int y, input bit cs,
                                output logic [8:0] dy, output logic er);
    int lp, raw;
    bit bad;
    lp  = cs ? int'(y % 4 == 0) : int'((y % 4 == 0) && ((y % 100 != 0) || (y % 400 == 0)));
    raw = d + ((lp != 0 && m > 2) ? 1 : 0);
    if (m >= 1 && m <= 12)
      for (int i = 1; i < m; i++) raw += mlen(i, 0);
    bad = (m == 0) || (m > 12) || (d == 0) || (d > mlen(m, lp));
`ifdef DOY_SCHED_ERR_CHECK_EN
    er = bad;
    dy = bad ? 9'd0 : raw[8:0];
`else
    er = 1'b0;
    dy = raw[8:0];
    if (bad) dy = raw[8:0];
`endif
  endfunction

  task automatic push(input logic id, input int d, input int m, input int y);
    exp_t e;
    e.id = id;
    model(d, m, y, 1'b0, e.dg, e.eg);
    model(d, m, y, 1'b1, e.dj, e.ej);
    q.push_back(e);
  endtask

  // Sample at the falling edge, then advance past the next rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    hs0 = req0Valid && rdy0[0];
    hs1 = req1Valid && rdy1[0];
    if (rst_n) begin
      if (hs0 || hs1) hs_cyc = cyc;
      for (int k = 0; k < 2; k++) begin
        chk("one_ready", 32'(rdy0[k] & rdy1[k]), 0);
        chk("ready_busy", 32'(rv[k] & (rdy0[k] | rdy1[k])), 0);
        if (prv_rv[k] && !prv_rr) begin
          chk("hold_valid", 32'(rv[k]), 1);
          chk("hold_doy", 32'(doy[k]), 32'(prv_doy[k]));
          chk("hold_id", 32'(rid[k]), 32'(prv_id[k]));
          chk("hold_err", 32'(rerr[k]), 32'(prv_err[k]));
        end
      end
      if (rv[0] && !prv_rv[0]) chk("latency", 32'(cyc - hs_cyc), 2);
      if (rv[0] && respReady) begin
        checks++;
        assert (q.size() > 0) else begin
          errors++;
          $error("FAIL sb_empty: observed unexpected result doy=%0d expected none", doy[0]);
        end
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("j_valid", 32'(rv[1]), 1);
          chk("g_id", 32'(rid[0]), 32'(e.id));
          chk("g_doy", 32'(doy[0]), 32'(e.dg));
          chk("g_err", 32'(rerr[0]), 32'(e.eg));
          chk("j_id", 32'(rid[1]), 32'(e.id));
          chk("j_doy", 32'(doy[1]), 32'(e.dj));
          chk("j_err", 32'(rerr[1]), 32'(e.ej));
        end
      end
      for (int k = 0; k < 2; k++) begin
        prv_rv[k] = rv[k]; prv_doy[k] = doy[k]; prv_id[k] = rid[k]; prv_err[k] = rerr[k];
      end
      prv_rr = respReady;
    end else begin
      prv_rv[0] = 1'b0; prv_rv[1] = 1'b0; prv_rr = 1'b1;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic wait_hs(input logic id);
    bit ok = 0;
    for (int n = 0; n < 40 && !ok; n++) begin
      tick();
      if (!id && hs0) begin req0Valid = 1'b0; ok = 1; end
      if (id && hs1)  begin req1Valid = 1'b0; ok = 1; end
    end
    chk("hs_timeout", 32'(ok), 1);
  endtask

  task automatic drive(input logic id, input int d, input int m, input int y);
    if (!id) begin
      req0DayOfMonth = 6'(d); req0Month = 4'(m); req0Year = 11'(y); req0Valid = 1'b1;
    end else begin
      req1DayOfMonth = 6'(d); req1Month = 4'(m); req1Year = 11'(y); req1Valid = 1'b1;
    end
    push(id, d, m, y);
  endtask

  task automatic send1(input logic id, input int d, input int m, input int y);
    drive(id, d, m, y);
    wait_hs(id);
  endtask

  // Both valid together; req0 is expected to be served first.
  task automatic pair(input int d0, input int m0, input int y0,
                      input int d1, input int m1, input int y1);
    drive(1'b0, d0, m0, y0);
    drive(1'b1, d1, m1, y1);
    for (int n = 0; n < 60 && (req0Valid || req1Valid); n++) begin
      tick();
      if (hs0) req0Valid = 1'b0;
      if (hs1) req1Valid = 1'b0;
    end
    chk("pair_timeout", 32'(req0Valid | req1Valid), 0);
  endtask

  task automatic drain();
    for (int n = 0; n < 40 && q.size() > 0; n++) tick();
    chk("drain", 32'(q.size()), 0);
  endtask

  initial begin
    prv_rv[0] = 1'b0; prv_rv[1] = 1'b0; prv_rr = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < 2; k++) begin
      chk("rst_valid", 32'(rv[k]), 0);
      chk("rst_id", 32'(rid[k]), 0);
      chk("rst_err", 32'(rerr[k]), 0);
      chk("rst_doy", 32'(doy[k]), 0);
    end
    respReady = 1'b1;

    pair(23, 6, 1996, 29, 8, 2004);
    drain();
    pair(23, 6, 1996, 29, 8, 2004);
    drain();

    send1(1'b0, 24, 3, 2002);
    drain();
    send1(1'b0, 31, 12, 2009);
    drain();

    // Result held under backpressure while req1 waits.
    respReady = 1'b0;
    send1(1'b0, 10, 2, 2003);
    drive(1'b1, 5, 5, 2005);
    for (int i = 0; i < 6; i++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        chk("bp_rdy0", 32'(rdy0[k]), 0);
        chk("bp_rdy1", 32'(rdy1[k]), 0);
        chk("bp_valid", 32'(rv[k]), 1);
      end
    end
    respReady = 1'b1;
    tick();
    chk("bp_consumed", 32'(rv[0] | rv[1]), 0);
    wait_hs(1'b1);
    drain();

    send1(1'b0, 29, 2, 1900);
    drain();
    send1(1'b1, 0, 5, 2000);
    drain();
    send1(1'b0, 31, 4, 2001);
    drain();
    send1(1'b1, 10, 13, 2001);
    drain();
    send1(1'b0, 31, 1, 2047);
    drain();

    // Reset while the operand sits in CALC: result dropped, arbitration restarts.
    send1(1'b0, 15, 7, 2010);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    q.delete();
    chk("mid_rst_valid_g", 32'(rv[0]), 0);
    chk("mid_rst_valid_j", 32'(rv[1]), 0);
    for (int i = 0; i < 3; i++) tick();
    chk("mid_rst_idle", 32'(rv[0]), 0);
    pair(1, 3, 2001, 2, 3, 2001);
    drain();
    send1(1'b0, 13, 1, 1970);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
